capi_tag_tracker: RTL and testbench

CAPI_TAG_TRACKER -- requirements
Module: capi_tag_tracker

---
 rtl/capi_pkg.sv | 20 ++
 rtl/capi_priority_encoder.sv | 23 ++
 rtl/capi_tag_tracker.sv | 175 +++++++++++++++++
 tb/tb_capi_tag_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/capi_pkg.sv
// Shared CAPI definitions: tag type, tag tracker state encoding and the
// odd-parity helper used wherever a tag crosses the PSL interface.
package capi_pkg;

   localparam int CAPI_TAG_W = 8;

   typedef logic [CAPI_TAG_W-1:0] tag_t;

   typedef enum logic [1:0] {
      TRK_IDLE  = 2'd0,
      TRK_RUN   = 2'd1,
      TRK_DRAIN = 2'd2
   } trk_state_e;

   // Zero-extension does not change the reduction, so narrower fields can be passed in.
   function automatic logic odd_parity(input logic [31:0] v);
      return ~^v;
   endfunction

endpackage

// File: rtl/capi_priority_encoder.sv
// Finds the lowest-numbered set bit of req_i (the free-tag vector).
module capi_priority_encoder #(
   parameter int NUM_TAGS  = 32,
   parameter int TAG_WIDTH = 8
) (
   input  logic [NUM_TAGS-1:0]  req_i,
   output logic                 any_o,
   output logic [TAG_WIDTH-1:0] idx_o
);

   // Scanning downwards lets the lowest set bit be the last one written.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            any_o = 1'b1;
            idx_o = TAG_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/capi_tag_tracker.sv
// CAPI command tag tracker: hands out free tags against PSL credits, retires
// them on responses and flags parity, tag and credit protocol violations.
module capi_tag_tracker
   import capi_pkg::*;
#(
   parameter int NUM_TAGS     = 32,
   parameter int TAG_WIDTH    = $bits(tag_t),
   parameter int CREDIT_WIDTH = 9
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [7:0]              room,
   input  logic                    stop,
   input  logic                    req_valid,
   output logic                    req_ready,
   output logic [TAG_WIDTH-1:0]    alloc_tag,
   output logic                    alloc_tag_parity,
   input  logic                    rsp_valid,
   input  logic [TAG_WIDTH-1:0]    rsp_tag,
   input  logic                    rsp_tag_parity,
   input  logic [CREDIT_WIDTH-1:0] rsp_credits,
   output logic [9:0]              credits,
   output logic [TAG_WIDTH:0]      outstanding,
   output logic                    running,
   output logic                    done,
   output logic                    parity_error,
   output logic                    tag_error,
   output logic                    credit_error
);

   localparam int SUM_W = ((CREDIT_WIDTH > 10) ? CREDIT_WIDTH : 10) + 2;

   trk_state_e                 state_q, state_d;
   logic [NUM_TAGS-1:0]        busy_q, busy_d;
   logic [9:0]                 credits_q, credits_d;
   logic [7:0]                 room_q, room_d;
   logic [TAG_WIDTH:0]         outst_q, outst_d;
   logic                       done_q, done_d;
   logic                       perr_q, perr_d;
   logic                       terr_q, terr_d;
   logic                       cerr_q, cerr_d;

   logic                       free_any;
   logic [TAG_WIDTH-1:0]       free_idx;
   logic                       grant;
   logic                       rsp_par_ok;
   logic                       rsp_hit;
   logic signed [SUM_W-1:0]    cred_ext, rsp_ext, grant_s, sum;
   logic [10:0]                sat;

   // Returns {overflow_flag, clamped_credits}.
   function automatic logic [10:0] saturate(input logic signed [SUM_W-1:0] s,
                                            input logic [7:0]              r);
      if (s < 0)
         return {1'b1, 10'd0};
      else if (s > SUM_W'(r))
         return {1'b1, 2'b00, r};
      else
         return {1'b0, s[9:0]};
   endfunction

   capi_priority_encoder #(
      .NUM_TAGS  (NUM_TAGS),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_free_enc (
      .req_i (~busy_q),
      .any_o (free_any),
      .idx_o (free_idx)
   );

   assign req_ready        = (state_q == TRK_RUN) && (credits_q != 10'd0) && free_any;
   assign grant            = req_valid && req_ready;
   assign alloc_tag        = free_idx;
   assign alloc_tag_parity = odd_parity(32'(free_idx));
   assign rsp_par_ok       = (rsp_tag_parity == odd_parity(32'(rsp_tag)));

   // Out-of-range tags never match an index, so they read as not busy.
   always_comb begin
      rsp_hit = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (rsp_tag == TAG_WIDTH'(i)) rsp_hit = busy_q[i];
      end
   end

   assign cred_ext = SUM_W'(credits_q);
   assign rsp_ext  = rsp_valid ? SUM_W'($signed(rsp_credits)) : '0;
   assign grant_s  = grant ? SUM_W'(1) : '0;
   assign sum      = cred_ext + rsp_ext - grant_s;

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      credits_d = credits_q;
      room_d    = room_q;
      done_d    = 1'b0;
      perr_d    = perr_q;
      terr_d    = terr_q;
      cerr_d    = cerr_q;
      sat       = '0;
      if (state_q == TRK_IDLE && start) begin
         state_d   = TRK_RUN;
         room_d    = room;
         credits_d = {2'b00, room};
         busy_d    = '0;
         perr_d    = 1'b0;
         terr_d    = 1'b0;
         cerr_d    = 1'b0;
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (grant && free_idx == TAG_WIDTH'(i))
               busy_d[i] = 1'b1;
            if (rsp_valid && rsp_par_ok && rsp_tag == TAG_WIDTH'(i) && busy_q[i])
               busy_d[i] = 1'b0;
         end
         if (rsp_valid) begin
            if (!rsp_par_ok)
               perr_d = 1'b1;
            else if (!rsp_hit)
               terr_d = 1'b1;
         end
         sat       = saturate(sum, room_q);
         credits_d = sat[9:0];
         if (sat[10]) cerr_d = 1'b1;
         case (state_q)
            TRK_RUN:   if (stop) state_d = TRK_DRAIN;
            TRK_DRAIN: if (busy_q == '0) begin
               state_d = TRK_IDLE;
               done_d  = 1'b1;
            end
            default:   ;
         endcase
      end
   end

   always_comb begin
      outst_d = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         outst_d = outst_d + (TAG_WIDTH+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= TRK_IDLE;
         busy_q    <= '0;
         credits_q <= '0;
         room_q    <= '0;
         outst_q   <= '0;
         done_q    <= 1'b0;
         perr_q    <= 1'b0;
         terr_q    <= 1'b0;
         cerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         credits_q <= credits_d;
         room_q    <= room_d;
         outst_q   <= outst_d;
         done_q    <= done_d;
         perr_q    <= perr_d;
         terr_q    <= terr_d;
         cerr_q    <= cerr_d;
      end
   end

   assign credits      = credits_q;
   assign outstanding  = outst_q;
   assign running      = (state_q != TRK_IDLE);
   assign done         = done_q;
   assign parity_error = perr_q;
   assign tag_error    = terr_q;
   assign credit_error = cerr_q;

endmodule

// File: tb/tb_capi_tag_tracker.sv
// Bench for capi_tag_tracker: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural tracker model.
module tb_capi_tag_tracker;

   localparam int NT = 32;
   localparam int TW = 8;
   localparam int CW = 9;

   logic          clock = 1'b0;
   logic          reset_n, start, stop, req_valid, rsp_valid, rsp_tag_parity;
   logic [7:0]    room;
   logic [TW-1:0] rsp_tag;
   logic [CW-1:0] rsp_credits;
   logic          req_ready, alloc_tag_parity, running, done;
   logic          parity_error, tag_error, credit_error;
   logic [TW-1:0] alloc_tag;
   logic [9:0]    credits;
   logic [TW:0]   outstanding;

   always #5 clock = ~clock;

   capi_tag_tracker #(.NUM_TAGS(NT), .TAG_WIDTH(TW), .CREDIT_WIDTH(CW)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .room             (room),
      .stop             (stop),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .alloc_tag        (alloc_tag),
      .alloc_tag_parity (alloc_tag_parity),
      .rsp_valid        (rsp_valid),
      .rsp_tag          (rsp_tag),
      .rsp_tag_parity   (rsp_tag_parity),
      .rsp_credits      (rsp_credits),
      .credits          (credits),
      .outstanding      (outstanding),
      .running          (running),
      .done             (done),
      .parity_error     (parity_error),
      .tag_error        (tag_error),
      .credit_error     (credit_error)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: 0 = idle, 1 = run, 2 = drain.
   int m_state;
   bit m_busy[NT];
   int m_cred, m_room;
   bit m_perr, m_terr, m_cerr, m_done;

   int exp_tag[4] = '{0, 1, 2, 3};
   int exp_par[4] = '{1, 0, 0, 1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic bit good_par(input int t);
      return ($countones(t) % 2 == 0);
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NT; i++) c += m_busy[i];
      return c;
   endfunction

   function automatic int m_lowest_free();
      for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   function automatic bit m_ready();
      return (m_state == 1) && (m_cred > 0) && (m_lowest_free() >= 0);
   endfunction

   task automatic model_reset();
      m_state = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cred = 0; m_room = 0;
      m_perr = 0; m_terr = 0; m_cerr = 0; m_done = 0;
   endtask

   task automatic model_advance(input bit st, input int rm, input bit sp, input bit rv,
                                input bit sv, input int tg, input bit tp, input int cr);
      int lf = m_lowest_free();
      bit g  = rv && m_ready();
      bit was_empty = (m_count() == 0);
      bit nb[NT];
      int c;
      if (m_state == 0 && st) begin
         m_state = 1; m_room = rm; m_cred = rm;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_perr = 0; m_terr = 0; m_cerr = 0; m_done = 0;
         return;
      end
      nb = m_busy;
      if (g) nb[lf] = 1'b1;
      c = m_cred - (g ? 1 : 0);
      if (sv) begin
         c += cr;
         if (tp != good_par(tg)) m_perr = 1;
         else if (tg >= NT || !m_busy[tg]) m_terr = 1;
         else nb[tg] = 1'b0;
      end
      if (c < 0) begin c = 0; m_cerr = 1; end
      else if (c > m_room) begin c = m_room; m_cerr = 1; end
      m_done = 0;
      if (m_state == 1 && sp) m_state = 2;
      else if (m_state == 2 && was_empty) begin m_state = 0; m_done = 1; end
      m_busy = nb;
      m_cred = c;
   endtask

   task automatic check_all();
      bit r = m_ready();
      check("req_ready", req_ready, r);
      if (r) begin
         check("alloc_tag", alloc_tag, m_lowest_free());
         check("alloc_par", alloc_tag_parity, good_par(m_lowest_free()));
      end
      check("credits", credits, m_cred);
      check("outstanding", outstanding, m_count());
      check("running", running, m_state != 0);
      check("done", done, m_done);
      check("parity_error", parity_error, m_perr);
      check("tag_error", tag_error, m_terr);
      check("credit_error", credit_error, m_cerr);
   endtask

   task automatic step(input bit st, input int rm, input bit sp, input bit rv,
                       input bit sv, input int tg, input bit tp, input int cr);
      @(negedge clock);
      start = st; room = rm[7:0]; stop = sp; req_valid = rv;
      rsp_valid = sv; rsp_tag = tg[TW-1:0]; rsp_tag_parity = tp; rsp_credits = cr[CW-1:0];
      #1 check_all();
      model_advance(st, rm, sp, rv, sv, tg, tp, cr);
      @(posedge clock);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3;
      start = 0; stop = 0; req_valid = 0; rsp_valid = 0;
      rsp_tag = '0; rsp_tag_parity = 0; rsp_credits = '0; room = '0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_credits", credits, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_errors", {parity_error, tag_error, credit_error}, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      start = 0; stop = 0; req_valid = 0; rsp_valid = 0;
      rsp_tag = '0; rsp_tag_parity = 0; rsp_credits = '0; room = '0;
      model_reset();
      do_reset();

      // Four credits: tags 0..3 with parities 1,0,0,1, then no more grants.
      step(1, 4, 0, 0, 0, 0, 0, 0); #1;
      check("d023_tag0", alloc_tag, exp_tag[0]);
      check("d023_par0", alloc_tag_parity, exp_par[0]);
      for (int i = 0; i < 6; i++) begin
         step(0, 4, 0, 1, 0, 0, 0, 0); #1;
         if (i < 3) begin
            check("d023_tag", alloc_tag, exp_tag[i+1]);
            check("d023_par", alloc_tag_parity, exp_par[i+1]);
         end else begin
            check("d023_ready", req_ready, 0);
         end
      end
      check("d023_credits", credits, 0);
      check("d023_outst", outstanding, 4);

      // Freeing tag 2 with a credit makes it the next grant.
      step(0, 4, 0, 0, 1, 2, 0, 1); #1;
      check("d024_outst", outstanding, 3);
      check("d024_credits", credits, 1);
      check("d024_ready", req_ready, 1);
      check("d024_tag", alloc_tag, 2);
      step(0, 4, 0, 1, 0, 0, 0, 0); #1;
      check("d024_regrant", outstanding, 4);

      step(0, 4, 0, 0, 1, 1, 1, 0); #1;
      check("d025_perr", parity_error, 1);
      check("d025_outst", outstanding, 4);

      step(0, 4, 0, 0, 1, 5, 1, 0); #1;
      check("d026_terr", tag_error, 1);
      step(0, 4, 0, 0, 1, 3, 1, -1); #1;
      check("d026_cerr", credit_error, 1);
      check("d026_credits", credits, 0);
      check("d026_outst", outstanding, 3);

      step(0, 4, 0, 0, 1, 0, 1, 2); #1;
      check("d027_pre_credits", credits, 2);
      step(0, 4, 0, 1, 1, 1, 0, 1); #1;
      check("d027_credits", credits, 2);
      check("d027_outst", outstanding, 2);

      step(0, 4, 1, 0, 0, 0, 0, 0); #1;
      check("d028_running0", running, 1);
      step(0, 4, 0, 0, 1, 0, 1, 0); #1;
      check("d028_running1", running, 1);
      step(0, 4, 0, 0, 1, 2, 0, 0); #1;
      check("d028_running2", running, 1);
      check("d028_outst", outstanding, 0);
      step(0, 4, 0, 0, 0, 0, 0, 0); #1;
      check("d028_idle", running, 0);
      check("d028_done", done, 1);
      step(0, 4, 0, 0, 0, 0, 0, 0); #1;
      check("d028_done_off", done, 0);

      // Reset in the middle of a run with tags outstanding and an error set.
      step(1, 10, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 10, 0, 1, 0, 0, 0, 0);
      step(0, 10, 0, 0, 1, 0, 0, 0);
      do_reset();

      for (int n = 0; n < 3000; n++) begin
         bit st, sp, rv, sv, tp;
         int rm, tg, cr;
         st = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
         sp = ($urandom_range(0, 30) == 0);
         rv = $urandom_range(0, 1) == 1;
         sv = ($urandom_range(0, 9) < 4);
         rm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 40));
         tg = int'($urandom_range(0, 39));
         if ($urandom_range(0, 9) < 7 && m_count() > 0) begin
            int j = int'($urandom_range(0, NT - 1));
            while (!m_busy[j]) j = (j + 1) % NT;
            tg = j;
         end
         tp = good_par(tg) ^ ($urandom_range(0, 15) == 0);
         cr = int'($urandom_range(0, 5)) - 2;
         step(st, rm, sp, rv, sv, tg, tp, cr);
         if (n == 1500) do_reset();
      end
      @(negedge clock);
      #1 check_all();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
